// File: rtl/vtg_pkg.sv
// Shared definitions for the raster timing generator:
// config map, timing record and range decode helpers.
package vtg_pkg;

    localparam int VTG_W = 9;

    localparam logic [3:0] VTG_H_TOTAL  = 4'd0;
    localparam logic [3:0] VTG_HB_START = 4'd1;
    localparam logic [3:0] VTG_HB_END   = 4'd2;
    localparam logic [3:0] VTG_HS_START = 4'd3;
    localparam logic [3:0] VTG_HS_END   = 4'd4;
    localparam logic [3:0] VTG_V_TOTAL  = 4'd5;
    localparam logic [3:0] VTG_VB_START = 4'd6;
    localparam logic [3:0] VTG_VB_END   = 4'd7;
    localparam logic [3:0] VTG_VS_START = 4'd8;
    localparam logic [3:0] VTG_VS_END   = 4'd9;
    localparam logic [3:0] VTG_IRQ_LINE = 4'd10;
    localparam logic [3:0] VTG_IRQ_EN   = 4'd11;

    typedef struct packed {
        logic [VTG_W-1:0] h_total;
        logic [VTG_W-1:0] hb_start;
        logic [VTG_W-1:0] hb_end;
        logic [VTG_W-1:0] hs_start;
        logic [VTG_W-1:0] hs_end;
        logic [VTG_W-1:0] v_total;
        logic [VTG_W-1:0] vb_start;
        logic [VTG_W-1:0] vb_end;
        logic [VTG_W-1:0] vs_start;
        logic [VTG_W-1:0] vs_end;
    } vtg_timing_t;

    // s > e describes a window that wraps through zero
    function automatic logic in_range(
        input logic [VTG_W-1:0] x,
        input logic [VTG_W-1:0] s,
        input logic [VTG_W-1:0] e
    );
        if (s <= e)
            return (s <= x) && (x < e);
        return (x >= s) || (x < e);
    endfunction

    function automatic vtg_timing_t vtg_clamp(input vtg_timing_t t);
        vtg_timing_t r;
        r = t;
        if (t.h_total < VTG_W'(2))
            r.h_total = VTG_W'(2);
        if (t.v_total < VTG_W'(2))
            r.v_total = VTG_W'(2);
        return r;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel-enable, config bus and raster outputs of the timing generator.
interface video_timing_gen_if
    import vtg_pkg::*;
#(
    parameter int W = VTG_W
) ();

    logic         pix_ce;
    logic         cfg_we;
    logic [3:0]   cfg_addr;
    logic [W-1:0] cfg_wdata;

    logic [W-1:0] hpos;
    logic [W-1:0] vpos;
    logic         hblank;
    logic         hsync;
    logic         vblank;
    logic         vsync;
    logic         display_on;
    logic         line_start;
    logic         frame_start;
    logic         line_irq;

    modport master (
        output pix_ce, cfg_we, cfg_addr, cfg_wdata,
        input  hpos, vpos, hblank, hsync, vblank, vsync,
        input  display_on, line_start, frame_start, line_irq
    );

    modport slave (
        input  pix_ce, cfg_we, cfg_addr, cfg_wdata,
        output hpos, vpos, hblank, hsync, vblank, vsync,
        output display_on, line_start, frame_start, line_irq
    );

endinterface

// File: rtl/video_timing_gen_axis.sv
// One raster axis: position counter plus registered blank/sync decode
// taken from the next count so flags line up with the counter.
module vtg_axis
    import vtg_pkg::*;
#(
    parameter int W   = VTG_W,
    parameter int BS0 = 0,
    parameter int BE0 = 0,
    parameter int SS0 = 0,
    parameter int SE0 = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_adv,
    input  logic [W-1:0] i_total,
    input  logic [W-1:0] i_bs,
    input  logic [W-1:0] i_be,
    input  logic [W-1:0] i_ss,
    input  logic [W-1:0] i_se,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_nxt,
    output logic         o_wrap,
    output logic         o_blank,
    output logic         o_sync
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic BLANK0 =
        in_range('0, VTG_W'(BS0), VTG_W'(BE0));
    localparam logic SYNC0 =
        in_range('0, VTG_W'(SS0), VTG_W'(SE0));

    logic [W-1:0] r_cnt;
    logic         r_blank;
    logic         r_sync;

    assign o_wrap = (r_cnt == i_total - ONE);
    assign o_nxt  = o_wrap ? '0 : r_cnt + ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_blank <= BLANK0;
            r_sync  <= SYNC0;
        end else if (i_adv) begin
            r_cnt   <= o_nxt;
            r_blank <= in_range(o_nxt, i_bs, i_be);
            r_sync  <= in_range(o_nxt, i_ss, i_se);
        end
    end

    assign o_cnt   = r_cnt;
    assign o_blank = r_blank;
    assign o_sync  = r_sync;

endmodule

// File: rtl/video_timing_gen.sv
// Programmable CRT raster timing generator with shadowed timing,
// line/frame strobes and a raster-line interrupt.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int W        = VTG_W,
    parameter int H_TOTAL  = 390,
    parameter int HB_START = 256,
    parameter int HB_END   = 0,
    parameter int HS_START = 300,
    parameter int HS_END   = 332,
    parameter int V_TOTAL  = 258,
    parameter int VB_START = 240,
    parameter int VB_END   = 16,
    parameter int VS_START = 250,
    parameter int VS_END   = 256
) (
    input  logic              clk_pixel,
    input  logic              rst_n,
    video_timing_gen_if.slave bus
);

    localparam vtg_timing_t DEF = '{
        h_total:  VTG_W'(H_TOTAL),
        hb_start: VTG_W'(HB_START),
        hb_end:   VTG_W'(HB_END),
        hs_start: VTG_W'(HS_START),
        hs_end:   VTG_W'(HS_END),
        v_total:  VTG_W'(V_TOTAL),
        vb_start: VTG_W'(VB_START),
        vb_end:   VTG_W'(VB_END),
        vs_start: VTG_W'(VS_START),
        vs_end:   VTG_W'(VS_END)
    };

    vtg_timing_t  r_pend;
    vtg_timing_t  r_act;
    vtg_timing_t  w_pend;
    vtg_timing_t  w_act_nxt;
    logic [W-1:0] r_irq_line;
    logic         r_irq_en;
    logic         r_line_start;
    logic         r_frame_start;
    logic         r_line_irq;

    logic         w_h_wrap;
    logic         w_v_wrap;
    logic         w_v_adv;
    logic         w_copy;
    logic [W-1:0] w_hpos;
    logic [W-1:0] w_vpos;
    logic [W-1:0] w_hnxt;
    logic [W-1:0] w_vnxt;
    logic         w_hblank;
    logic         w_hsync;
    logic         w_vblank;
    logic         w_vsync;

    // Pending bank with this cycle's write merged in
    always_comb begin
        w_pend = r_pend;
        if (bus.cfg_we) begin
            case (bus.cfg_addr)
                VTG_H_TOTAL:  w_pend.h_total  = bus.cfg_wdata;
                VTG_HB_START: w_pend.hb_start = bus.cfg_wdata;
                VTG_HB_END:   w_pend.hb_end   = bus.cfg_wdata;
                VTG_HS_START: w_pend.hs_start = bus.cfg_wdata;
                VTG_HS_END:   w_pend.hs_end   = bus.cfg_wdata;
                VTG_V_TOTAL:  w_pend.v_total  = bus.cfg_wdata;
                VTG_VB_START: w_pend.vb_start = bus.cfg_wdata;
                VTG_VB_END:   w_pend.vb_end   = bus.cfg_wdata;
                VTG_VS_START: w_pend.vs_start = bus.cfg_wdata;
                VTG_VS_END:   w_pend.vs_end   = bus.cfg_wdata;
                default: ;
            endcase
        end
    end

    assign w_v_adv   = bus.pix_ce & w_h_wrap;
    assign w_copy    = w_v_adv & w_v_wrap;
    assign w_act_nxt = w_copy ? vtg_clamp(w_pend) : r_act;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_pend        <= DEF;
            r_act         <= DEF;
            r_irq_line    <= '0;
            r_irq_en      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_irq    <= 1'b0;
        end else begin
            r_pend <= w_pend;
            r_act  <= w_act_nxt;
            if (bus.cfg_we && bus.cfg_addr == VTG_IRQ_LINE)
                r_irq_line <= bus.cfg_wdata;
            if (bus.cfg_we && bus.cfg_addr == VTG_IRQ_EN)
                r_irq_en <= bus.cfg_wdata[0];
            r_line_start  <= bus.pix_ce & (w_hnxt == '0);
            r_frame_start <= w_copy;
            r_line_irq    <= w_v_adv & r_irq_en &
                             (w_vnxt == r_irq_line);
        end
    end

    vtg_axis #(
        .W   (W),
        .BS0 (HB_START),
        .BE0 (HB_END),
        .SS0 (HS_START),
        .SE0 (HS_END)
    ) u_h (
        .clk     (clk_pixel),
        .rst_n   (rst_n),
        .i_adv   (bus.pix_ce),
        .i_total (r_act.h_total),
        .i_bs    (w_act_nxt.hb_start),
        .i_be    (w_act_nxt.hb_end),
        .i_ss    (w_act_nxt.hs_start),
        .i_se    (w_act_nxt.hs_end),
        .o_cnt   (w_hpos),
        .o_nxt   (w_hnxt),
        .o_wrap  (w_h_wrap),
        .o_blank (w_hblank),
        .o_sync  (w_hsync)
    );

    vtg_axis #(
        .W   (W),
        .BS0 (VB_START),
        .BE0 (VB_END),
        .SS0 (VS_START),
        .SE0 (VS_END)
    ) u_v (
        .clk     (clk_pixel),
        .rst_n   (rst_n),
        .i_adv   (w_v_adv),
        .i_total (r_act.v_total),
        .i_bs    (w_act_nxt.vb_start),
        .i_be    (w_act_nxt.vb_end),
        .i_ss    (w_act_nxt.vs_start),
        .i_se    (w_act_nxt.vs_end),
        .o_cnt   (w_vpos),
        .o_nxt   (w_vnxt),
        .o_wrap  (w_v_wrap),
        .o_blank (w_vblank),
        .o_sync  (w_vsync)
    );

    assign bus.hpos        = w_hpos;
    assign bus.vpos        = w_vpos;
    assign bus.hblank      = w_hblank;
    assign bus.hsync       = w_hsync;
    assign bus.vblank      = w_vblank;
    assign bus.vsync       = w_vsync;
    assign bus.display_on  = ~(w_hblank | w_vblank);
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
    assign bus.line_irq    = r_line_irq;

endmodule
